free_slot_scanner: RTL

FREE_SLOT_SCANNER -- requirements
Module: free_slot_scanner

---
 rtl/free_slot_scanner_pkg.sv | 30 +++
 rtl/slot_lane_cmp.sv | 27 ++
 rtl/free_slot_scanner.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/free_slot_scanner_pkg.sv
// Shared game package for the free-slot scanner.
// Holds the board-level defaults (map size, slot code width, empty-slot
// code), the request mode encoding and the scanner FSM state encoding.
package free_slot_scanner_pkg;

    localparam int MAP_SLOTS_DEF = 144;  // card slots on the board map
    localparam int CARD_W_DEF    = 6;    // bits per slot code
    localparam int NO_CARD_DEF   = 54;   // slot code meaning "empty"

    // Request modes presented on the mode input
    typedef enum logic [1:0] {
        MODE_LOWEST  = 2'd0,
        MODE_HIGHEST = 2'd1,
        MODE_COUNT   = 2'd2,
        MODE_NTH     = 2'd3
    } scan_mode_e;

    // Scanner controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    // Integer ceiling division, used for the beat count of a window
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/slot_lane_cmp.sv
// slot_lane_cmp: purely combinational per-lane empty-slot detector.
// Ports:
//   lane_codes  in  LANES*CARD_W  slot codes, lane l at [l*CARD_W +: CARD_W]
//   lane_valid  in  LANES         lane holds a real, in-map window slot
//   free_mask   out LANES         lane is valid and its code is NO_CARD
module slot_lane_cmp
    import free_slot_scanner_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int CARD_W  = CARD_W_DEF,
    parameter int NO_CARD = NO_CARD_DEF
) (
    input  logic [LANES*CARD_W-1:0] lane_codes,
    input  logic [LANES-1:0]        lane_valid,
    output logic [LANES-1:0]        free_mask
);

    // Invalid lanes are forced occupied regardless of their code
    always_comb begin
        free_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            free_mask[l] = lane_valid[l] &&
                           (lane_codes[l*CARD_W +: CARD_W] == CARD_W'(NO_CARD));
        end
    end

endmodule

// File: rtl/free_slot_scanner.sv
// free_slot_scanner: searches a WIN_LEN-slot window of the board map for
// empty slots, LANES slots per cycle, over a snapshot taken at request time.
// Ports:
//   clk, rst (async, active-low), interboard_rst (sync clear, active-high)
//   map       board state, slot k at map[MAP_SLOTS*CARD_W-1-k*CARD_W -: CARD_W]
//   start     one-cycle request, accepted only when idle
//   mode      0 lowest free, 1 highest free, 2 count free, 3 nth free
//   win_base  absolute slot of window index 0
//   nth       1-based rank for mode 3
//   busy      high while a request is in flight (SCAN and DONE)
//   done      one-cycle pulse, result outputs valid
//   found, slot_idx, free_cnt   registered result, held until next done
module free_slot_scanner
    import free_slot_scanner_pkg::*;
#(
    parameter  int MAP_SLOTS = MAP_SLOTS_DEF,
    parameter  int CARD_W    = CARD_W_DEF,
    parameter  int NO_CARD   = NO_CARD_DEF,
    parameter  int WIN_LEN   = 36,
    parameter  int LANES     = 4,
    localparam int IDX_W     = $clog2(WIN_LEN),
    localparam int CNT_W     = $clog2(WIN_LEN + 1),
    localparam int BASE_W    = $clog2(MAP_SLOTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        interboard_rst,
    input  logic [MAP_SLOTS*CARD_W-1:0] map,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [BASE_W-1:0]           win_base,
    input  logic [CNT_W-1:0]            nth,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [IDX_W-1:0]            slot_idx,
    output logic [CNT_W-1:0]            free_cnt
);

    localparam int BEATS  = ceil_div(WIN_LEN, LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MAP_W  = MAP_SLOTS * CARD_W;

    scan_state_e                state_q, state_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [MAP_W-1:0]           map_q, map_d;
    scan_mode_e                 mode_q, mode_d;
    logic [BASE_W-1:0]          base_q, base_d;
    logic [CNT_W-1:0]           nth_q, nth_d;

    // Accumulators carried across beats
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       first_hit_q, first_hit_d;
    logic [IDX_W-1:0]           first_idx_q, first_idx_d;
    logic                       last_hit_q, last_hit_d;
    logic [IDX_W-1:0]           last_idx_q, last_idx_d;
    logic                       nth_hit_q, nth_hit_d;
    logic [IDX_W-1:0]           nth_idx_q, nth_idx_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       found_q, found_d;
    logic [IDX_W-1:0]           slot_idx_q, slot_idx_d;
    logic [CNT_W-1:0]           free_cnt_q, free_cnt_d;

    // Current-beat lane data
    int                         lane_pos_s [LANES];
    int                         lane_abs_s [LANES];
    logic [LANES*CARD_W-1:0]    lane_code_s;
    logic [LANES-1:0]           lane_valid_s;
    logic [LANES-1:0]           free_mask_s;

    // Accumulators after folding in the current beat
    logic [CNT_W-1:0]           cnt_acc_s;
    logic                       first_hit_acc_s;
    logic [IDX_W-1:0]           first_idx_acc_s;
    logic                       last_hit_acc_s;
    logic [IDX_W-1:0]           last_idx_acc_s;
    logic                       nth_hit_acc_s;
    logic [IDX_W-1:0]           nth_idx_acc_s;

    // Select the snapshot codes for this beat; lanes past the window end or
    // past the map end are marked invalid (occupied) and read slot 0 instead
    // so the part-select never leaves the map.
    always_comb begin
        lane_code_s  = '0;
        lane_valid_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_pos_s[l]   = int'(beat_q) * LANES + l;
            lane_abs_s[l]   = int'(base_q) + lane_pos_s[l];
            lane_valid_s[l] = (lane_pos_s[l] < WIN_LEN) && (lane_abs_s[l] < MAP_SLOTS);
            if (lane_valid_s[l]) begin
                lane_code_s[l*CARD_W +: CARD_W] =
                    map_q[MAP_W-1-lane_abs_s[l]*CARD_W -: CARD_W];
            end else begin
                lane_code_s[l*CARD_W +: CARD_W] = map_q[MAP_W-1 -: CARD_W];
            end
        end
    end

    slot_lane_cmp #(
        .LANES   (LANES),
        .CARD_W  (CARD_W),
        .NO_CARD (NO_CARD)
    ) u_lane_cmp (
        .lane_codes (lane_code_s),
        .lane_valid (lane_valid_s),
        .free_mask  (free_mask_s)
    );

    // Fold this beat's free lanes, in ascending index order, into the
    // accumulators. The running count rises by one per free slot, so the
    // nth-rank match fires at most once per request.
    always_comb begin
        cnt_acc_s       = cnt_q;
        first_hit_acc_s = first_hit_q;
        first_idx_acc_s = first_idx_q;
        last_hit_acc_s  = last_hit_q;
        last_idx_acc_s  = last_idx_q;
        nth_hit_acc_s   = nth_hit_q;
        nth_idx_acc_s   = nth_idx_q;
        for (int l = 0; l < LANES; l++) begin
            if (free_mask_s[l]) begin
                cnt_acc_s      = cnt_acc_s + CNT_W'(1);
                last_hit_acc_s = 1'b1;
                last_idx_acc_s = IDX_W'(lane_pos_s[l]);
                if (!first_hit_acc_s) begin
                    first_hit_acc_s = 1'b1;
                    first_idx_acc_s = IDX_W'(lane_pos_s[l]);
                end else begin
                    first_idx_acc_s = first_idx_acc_s;
                end
                if ((nth_q != CNT_W'(0)) && (cnt_acc_s == nth_q)) begin
                    nth_hit_acc_s = 1'b1;
                    nth_idx_acc_s = IDX_W'(lane_pos_s[l]);
                end else begin
                    nth_hit_acc_s = nth_hit_acc_s;
                end
            end else begin
                cnt_acc_s = cnt_acc_s;
            end
        end
    end

    // Controller next-state, snapshot capture and result selection
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        map_d       = map_q;
        mode_d      = mode_q;
        base_d      = base_q;
        nth_d       = nth_q;
        cnt_d       = cnt_q;
        first_hit_d = first_hit_q;
        first_idx_d = first_idx_q;
        last_hit_d  = last_hit_q;
        last_idx_d  = last_idx_q;
        nth_hit_d   = nth_hit_q;
        nth_idx_d   = nth_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        slot_idx_d  = slot_idx_q;
        free_cnt_d  = free_cnt_q;

        if (interboard_rst) begin
            // Synchronous clear dominates, including a coincident start
            state_d     = S_IDLE;
            beat_d      = '0;
            map_d       = '0;
            mode_d      = MODE_LOWEST;
            base_d      = '0;
            nth_d       = '0;
            cnt_d       = '0;
            first_hit_d = 1'b0;
            first_idx_d = '0;
            last_hit_d  = 1'b0;
            last_idx_d  = '0;
            nth_hit_d   = 1'b0;
            nth_idx_d   = '0;
            busy_d      = 1'b0;
            found_d     = 1'b0;
            slot_idx_d  = '0;
            free_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_SCAN;
                        beat_d      = '0;
                        map_d       = map;
                        mode_d      = scan_mode_e'(mode);
                        base_d      = win_base;
                        nth_d       = nth;
                        cnt_d       = '0;
                        first_hit_d = 1'b0;
                        first_idx_d = '0;
                        last_hit_d  = 1'b0;
                        last_idx_d  = '0;
                        nth_hit_d   = 1'b0;
                        nth_idx_d   = '0;
                        busy_d      = 1'b1;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                S_SCAN: begin
                    cnt_d       = cnt_acc_s;
                    first_hit_d = first_hit_acc_s;
                    first_idx_d = first_idx_acc_s;
                    last_hit_d  = last_hit_acc_s;
                    last_idx_d  = last_idx_acc_s;
                    nth_hit_d   = nth_hit_acc_s;
                    nth_idx_d   = nth_idx_acc_s;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d    = S_DONE;
                        beat_d     = '0;
                        done_d     = 1'b1;
                        free_cnt_d = cnt_acc_s;
                        // Index accumulators stay 0 until hit, so a miss
                        // naturally reports slot_idx = 0.
                        case (mode_q)
                            MODE_LOWEST: begin
                                found_d    = first_hit_acc_s;
                                slot_idx_d = first_idx_acc_s;
                            end
                            MODE_HIGHEST: begin
                                found_d    = last_hit_acc_s;
                                slot_idx_d = last_idx_acc_s;
                            end
                            MODE_NTH: begin
                                found_d    = nth_hit_acc_s;
                                slot_idx_d = nth_idx_acc_s;
                            end
                            default: begin
                                found_d    = (cnt_acc_s != CNT_W'(0));
                                slot_idx_d = '0;
                            end
                        endcase
                    end else begin
                        state_d = S_SCAN;
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, snapshot and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            map_q       <= '0;
            mode_q      <= MODE_LOWEST;
            base_q      <= '0;
            nth_q       <= '0;
            cnt_q       <= '0;
            first_hit_q <= 1'b0;
            first_idx_q <= '0;
            last_hit_q  <= 1'b0;
            last_idx_q  <= '0;
            nth_hit_q   <= 1'b0;
            nth_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            slot_idx_q  <= '0;
            free_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            map_q       <= map_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            nth_q       <= nth_d;
            cnt_q       <= cnt_d;
            first_hit_q <= first_hit_d;
            first_idx_q <= first_idx_d;
            last_hit_q  <= last_hit_d;
            last_idx_q  <= last_idx_d;
            nth_hit_q   <= nth_hit_d;
            nth_idx_q   <= nth_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            slot_idx_q  <= slot_idx_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign slot_idx = slot_idx_q;
    assign free_cnt = free_cnt_q;

endmodule
